wbk_port_arbiter: RTL

- Owns the single register-file write port at writeback.
- Arbitrates between two sources: the in-order MEM2WBK pipeline FIFO head (empty/pop interface) and a long-latency divider result (valid/ready interface).
- Holds the divider result in a one-entry buffer. Gives the pipeline priority, but bounds divider starvation with a wait counter.
- Drives a registered write port to the register file, with one cycle of latency.

---
 rtl/wbk_port_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wbk_port_arbiter.sv
// Writeback port arbiter: merges the MEM2WBK FIFO head and a buffered
// divider result onto one registered register-file write port.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   PIPE_EMPTY_SM / PIPE_POP_SW    FIFO head status and pop strobe
//   PIPE_WB_RM/DEST_RM/DATA_RM     FIFO head write request
//   DIV_VALID_RX / DIV_READY_SW    divider result handshake
//   DIV_DEST_RX / DIV_DATA_RX      divider result payload
//   RF_WB_SW/DEST_SW/DATA_SW       registered register-file write port
//   DIV_FORCED_SW                  pulse: divider grant forced by starvation
module wbk_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PIPE_EMPTY_SM,
  output logic        PIPE_POP_SW,
  input  logic        PIPE_WB_RM,
  input  logic [5:0]  PIPE_DEST_RM,
  input  logic [31:0] PIPE_DATA_RM,
  input  logic        DIV_VALID_RX,
  output logic        DIV_READY_SW,
  input  logic [5:0]  DIV_DEST_RX,
  input  logic [31:0] DIV_DATA_RX,
  output logic        RF_WB_SW,
  output logic [5:0]  RF_DEST_SW,
  output logic [31:0] RF_DATA_SW,
  output logic        DIV_FORCED_SW
);

  localparam logic [3:0] MaxW = 4'(MAX_WAIT);

  typedef enum logic {
    NORMAL,
    STARVED
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        buf_v_q, buf_v_d;
  logic [5:0]  buf_dest_q;
  logic [31:0] buf_data_q;
  logic        rf_wb_q;
  logic [5:0]  rf_dest_q;
  logic [31:0] rf_data_q;
  logic        forced_q, forced_d;

  logic pipe_need;
  logic capture;
  logic div_grant;
  logic pop;
  logic use_pipe;
  logic use_div;

  assign pipe_need = !PIPE_EMPTY_SM && PIPE_WB_RM
                     && (PIPE_DEST_RM != 6'd0);

  // Ready depends only on buffer state, never on DIV_VALID_RX.
  assign DIV_READY_SW = !reset && !buf_v_q;
  assign capture      = DIV_VALID_RX && DIV_READY_SW;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    div_grant = 1'b0;
    pop       = 1'b0;
    forced_d  = 1'b0;
    unique case (state_q)
      NORMAL: begin
        div_grant = buf_v_q && !pipe_need;
        pop       = !PIPE_EMPTY_SM;
        if (buf_v_q && !div_grant) begin
          wait_d = wait_q + 4'd1;
          if (wait_d == MaxW) state_d = STARVED;
        end else if (div_grant) begin
          wait_d = 4'd0;
        end
      end
      STARVED: begin
        // A port-using head must stall so the divider can write.
        div_grant = buf_v_q;
        pop       = !PIPE_EMPTY_SM && !pipe_need;
        forced_d  = buf_v_q;
        wait_d    = 4'd0;
        state_d   = NORMAL;
      end
    endcase
  end

  always_comb begin
    buf_v_d = buf_v_q;
    if (div_grant) buf_v_d = 1'b0;
    if (capture)   buf_v_d = 1'b1;
  end

  // Pipe and divider never both use the port in one cycle.
  assign use_pipe = pop && pipe_need;
  assign use_div  = div_grant && (buf_dest_q != 6'd0);

  assign PIPE_POP_SW = !reset && pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NORMAL;
      wait_q     <= 4'd0;
      buf_v_q    <= 1'b0;
      buf_dest_q <= 6'd0;
      buf_data_q <= 32'd0;
      rf_wb_q    <= 1'b0;
      rf_dest_q  <= 6'd0;
      rf_data_q  <= 32'd0;
      forced_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      buf_v_q  <= buf_v_d;
      forced_q <= forced_d;
      if (capture) begin
        buf_dest_q <= DIV_DEST_RX;
        buf_data_q <= DIV_DATA_RX;
      end
      if (use_pipe) begin
        rf_wb_q   <= 1'b1;
        rf_dest_q <= PIPE_DEST_RM;
        rf_data_q <= PIPE_DATA_RM;
      end else if (use_div) begin
        rf_wb_q   <= 1'b1;
        rf_dest_q <= buf_dest_q;
        rf_data_q <= buf_data_q;
      end else begin
        rf_wb_q <= 1'b0;
      end
    end
  end

  assign RF_WB_SW      = rf_wb_q;
  assign RF_DEST_SW    = rf_dest_q;
  assign RF_DATA_SW    = rf_data_q;
  assign DIV_FORCED_SW = forced_q;

endmodule
